// File: rtl/alu_ctrl_pkg.sv
// ALU control codes and EX-stage FSM encoding.
// Shared between ALU_Control and the EX execution unit.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_MUL = 4'b0111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] code);
        return code inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MUL};
    endfunction

endpackage

// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier, one partial product per clock.
// Returns the low WIDTH bits of a*b after WIDTH iterations.
module seq_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic             run;

    always_comb begin
        acc_nxt = acc;
        if (mplier[0]) begin
            acc_nxt = acc + mcand;
        end
    end

    // product includes the current iteration so done can be consumed directly
    assign done    = run && (cnt == CW'(WIDTH - 1));
    assign product = acc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle_exec.sv
// EX-stage ALU: single-cycle logic/arith ops, iterative MUL with busy stall.
// Results are registered for the EX/MEM pipeline register.
module alu_multicycle_exec
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             illegal_o
);

    state_t           state;
    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_res;
    logic             legal;

    assign busy_o    = (state == MUL);
    assign accept    = valid_i && !busy_o;
    assign is_mul    = (ALUCtrl_i == ALU_MUL);
    assign mul_start = accept && is_mul;
    assign legal     = is_legal_op(ALUCtrl_i);

    // Illegal codes fall through to zero so zero_o reads 1 for them
    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            ALU_AND: alu_res = data1_i & data2_i;
            ALU_OR:  alu_res = data1_i | data2_i;
            ALU_ADD: alu_res = data1_i + data2_i;
            ALU_SUB: alu_res = data1_i - data2_i;
            default: alu_res = '0;
        endcase
    end

    seq_mul_unit #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk_i),
        .rst    (rst_i),
        .start  (mul_start),
        .a      (data1_i),
        .b      (data2_i),
        .done   (mul_done),
        .product(mul_product)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            data_o    <= '0;
            zero_o    <= 1'b1;
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= MUL;
                        end else begin
                            data_o    <= alu_res;
                            zero_o    <= (alu_res == '0);
                            valid_o   <= 1'b1;
                            illegal_o <= !legal;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        data_o  <= mul_product;
                        zero_o  <= (mul_product == '0);
                        valid_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
